// File: rtl/memory_responder.sv
// Fixed-latency word memory with a RISC-V style load/store front end.
// One request is handled at a time: IDLE -> WAIT -> DONE (ready pulse) -> IDLE.
module memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] Adr,
    input  logic [31:0] WD,
    input  logic [2:0]  funct3,
    output logic [31:0] RD,
    output logic        ready,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   adr_q, wd_q;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [31:0]   rd_q, rd_d;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          capture, enter_done;
    logic [31:0]   x_adr, x_wd;
    logic          x_we;
    logic [2:0]    x_f3;
    logic          x_byte, x_half, x_mis;
    logic [AW-1:0] x_idx;
    logic [3:0]    x_be;
    logic [31:0]   x_wdata, x_word, x_shifted, x_load;
    logic          unused_adr;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_done = (state_d == DONE) && (state_q != DONE);

    // With LATENCY=1 the capture edge is also the DONE edge, so use the live inputs in IDLE.
    always_comb begin
        x_adr = (state_q == IDLE) ? Adr    : adr_q;
        x_wd  = (state_q == IDLE) ? WD     : wd_q;
        x_we  = (state_q == IDLE) ? we     : we_q;
        x_f3  = (state_q == IDLE) ? funct3 : f3_q;
    end

    always_comb begin
        x_byte    = x_we ? (x_f3 == 3'b000) : (x_f3[1:0] == 2'b00);
        x_half    = x_we ? (x_f3 == 3'b001) : (x_f3[1:0] == 2'b01);
        x_mis     = (x_half && x_adr[0]) || (!x_byte && !x_half && (x_adr[1:0] != 2'b00));
        x_idx     = x_adr[AW+1:2];
        x_be      = 4'b1111;
        x_wdata   = x_wd;
        if (x_byte) begin
            x_be    = 4'b0001 << x_adr[1:0];
            x_wdata = {4{x_wd[7:0]}};
        end else if (x_half) begin
            x_be    = 4'b0011 << {x_adr[1], 1'b0};
            x_wdata = {2{x_wd[15:0]}};
        end
        x_word    = mem_q[x_idx];
        x_shifted = x_word >> {x_adr[1:0], 3'b000};
        x_load    = x_shifted;
        if (x_byte)
            x_load = {{24{x_shifted[7] & ~x_f3[2]}}, x_shifted[7:0]};
        else if (x_half)
            x_load = {{16{x_shifted[15] & ~x_f3[2]}}, x_shifted[15:0]};
        rd_d      = (x_we || x_mis) ? 32'h0 : x_load;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_done) rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture && !reset) begin
            adr_q <= Adr;
            wd_q  <= WD;
            we_q  <= we;
            f3_q  <= funct3;
        end
    end

    // NOTE: storage is deliberately not reset; contents survive reset and power up undefined.
    always_ff @(posedge clk) begin
        if (!reset && enter_done && x_we && !x_mis) begin
            for (int b = 0; b < 4; b++) begin
                if (x_be[b]) mem_q[x_idx][8*b +: 8] <= x_wdata[8*b +: 8];
            end
        end
    end

    assign unused_adr = ^x_adr[31:AW+2];
    assign ready      = (state_q == DONE);
    assign misaligned = ready && x_mis;
    assign RD         = rd_q;

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, sets the number of 32-bit words in internal storage; it SHALL be a power of two.
REQ-002 Parameter LATENCY, default 2, sets the number of cycles from request capture to response; it SHALL be at least 1.
REQ-003 Port clk, input, 1: single clock, all state on rising edge.
REQ-004 Port reset, input, 1: reset, synchronous and active-high.
REQ-005 Port req, input, 1: request strobe, sampled only in IDLE.
REQ-006 Port we, input, 1: 1 = store, 0 = load.
REQ-007 Port Adr, input, 32: byte address.
REQ-008 Port WD, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 Port funct3, input, 3: RISC-V access size/sign code.
REQ-010 Port RD, output, 32: load data, registered.
REQ-011 Port ready, output, 1: one-cycle response strobe.
REQ-012 Port misaligned, output, 1: error flag, valid only while ready=1.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, and DONE.
REQ-014 In IDLE, req=1 at a rising edge SHALL capture Adr, WD, we, and funct3, and SHALL load the latency counter with LATENCY-1.
- If LATENCY=1, the next state SHALL be DONE.
- Otherwise, the next state SHALL be WAIT.
REQ-015 WAIT SHALL decrement the counter each cycle and SHALL move to DONE when the counter reaches 1.
- Net effect: ready SHALL be high in the cycle beginning LATENCY edges after the capture edge.
REQ-016 ready SHALL be 1 for exactly one cycle, in DONE only, after which the FSM SHALL return to IDLE.
- A new request SHALL be accepted no earlier than the edge that leaves DONE.
REQ-017 req asserted in WAIT or DONE SHALL be ignored, with no queuing.
REQ-018 Word index SHALL be Adr[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-019 Load funct3 decode SHALL be:
- 000 LB, sign-extended.
- 001 LH, sign-extended.
- 010 LW.
- 100 LBU, zero-extended.
- 101 LHU, zero-extended.
- Any other code SHALL behave as LW.
REQ-020 Byte/half lane selection SHALL use Adr[1:0] (byte) or Adr[1] (half), little-endian.
REQ-021 Store funct3 decode SHALL be:
- 000 SB: writes only the addressed byte lane.
- 001 SH: writes only the addressed half lane.
- 010 SW and any other code: writes the full word.
REQ-022 A store SHALL update storage on the edge entering DONE; other lanes SHALL be preserved.
REQ-023 A load SHALL update RD on the edge entering DONE; a store SHALL set RD to 0.
REQ-024 RD SHALL hold its value from that edge until the next response edge.
REQ-025 Misalignment SHALL be defined as a half access with Adr[0]=1, or a word access with Adr[1:0]!=00.
- On misalignment: misaligned=1 with ready, no storage write, RD=0.
REQ-026 When not misaligned, misaligned SHALL be 0 with ready; outside DONE it SHALL be 0.
REQ-027 A load from a word stored in an earlier transaction SHALL return the stored value, with no hazard window.

Reset
REQ-028 When reset=1 at an edge, the block SHALL set:
- FSM to IDLE,
- ready to 0,
- misaligned to 0,
- RD to 0x00000000,
- counter to 0.
REQ-029 Reset during WAIT SHALL abort the transaction: no storage write and no ready pulse.
REQ-030 Reset SHALL NOT clear storage contents; storage power-up contents SHALL be undefined unless loaded by the bench.
REQ-031 A req asserted in the same cycle as reset SHALL be dropped.

Verification
REQ-032 LATENCY=2: SW Adr=0x10 WD=0xDEADBEEF, then LW Adr=0x10 -> first ready 2 cycles after capture with RD=0; second ready with RD=0xDEADBEEF, misaligned=0.
REQ-033 After REQ-032:
- LB Adr=0x13 -> RD=0xFFFFFFDE.
- LBU Adr=0x13 -> RD=0x000000DE.
- LH Adr=0x12 -> RD=0xFFFFDEAD.
- LHU Adr=0x10 -> RD=0x0000BEEF.
REQ-034 After REQ-032: SB Adr=0x11 WD=0x00000055, then LW Adr=0x10 -> RD=0xDEAD55EF.
REQ-035 LW Adr=0x12 and SH Adr=0x11 -> each gives ready with misaligned=1 and RD=0; a subsequent LW Adr=0x10 is unchanged.
REQ-036 DEPTH_WORDS=256:
- SW Adr=0x400 WD=0x12345678, then LW Adr=0x0 -> RD=0x12345678 (wrap).
- req held high continuously -> ready pulses every LATENCY+1 cycles.
REQ-037 SW Adr=0x20 WD=0x1 with reset pulsed during WAIT, then LW Adr=0x20 -> no ready during the aborted access; RD equals the prior contents of 0x20.
